conv_dp_acc_requant: RTL and testbench

// - Next-generation convolution arithmetic core: OC_PAR parallel dot-product accumulators of DP_SIZE lanes each.
// - Accumulation depth is runtime-programmable up to MAX_ACC_DEPTH.
// - Fuses the optional per-channel bias add, round-half-up and signed saturation to the OUT_WIDTH/OUT_FRAC output format.
// - Sits after the input line buffer; the result stream feeds the next layer directly with no external cast stage.

---
 rtl/conv_arith_pkg.sv | 53 +++++
 rtl/fixed_round_sat.sv | 32 +++
 rtl/conv_dp_acc_requant.sv | 148 ++++++++++++++
 tb/tb_conv_dp_acc_requant.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_arith_pkg.sv
// Shared width helpers, word typedefs and fixed-point align/round/saturate
// functions for the convolution arithmetic core.
package conv_arith_pkg;

   function automatic int acc_width(input int in_w, input int w_w, input int dp, input int depth);
      return in_w + w_w + $clog2(dp * depth);
   endfunction

   function automatic int acc_frac(input int in_frac, input int w_frac);
      return in_frac + w_frac;
   endfunction

   localparam int DEF_ACC_W = acc_width(16, 8, 4, 16);
   localparam int DEF_OUT_W = 16;

   typedef logic signed [DEF_ACC_W-1:0] acc_word_t;
   typedef logic signed [DEF_OUT_W-1:0] out_word_t;

   // Moves a value from src_frac to dst_frac fractional bits.
   function automatic logic signed [63:0] align_frac(input logic signed [63:0] v,
                                                     input int src_frac, input int dst_frac);
      logic signed [63:0] r;
      if (dst_frac >= src_frac) begin
         r = v <<< (dst_frac - src_frac);
      end else begin
         r = v >>> (src_frac - dst_frac);
      end
      return r;
   endfunction

   function automatic logic signed [63:0] round_sat(input logic signed [63:0] v, input int in_frac,
                                                    input int out_frac, input int out_w);
      logic signed [63:0] r;
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      if (out_frac < in_frac) begin
         r = (v + (64'sd1 <<< (in_frac - out_frac - 1))) >>> (in_frac - out_frac);
      end else begin
         r = v <<< (out_frac - in_frac);
      end
      max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (out_w - 1));
      if (r > max_v) begin
         r = max_v;
      end else if (r < min_v) begin
         r = min_v;
      end else begin
         r = r;
      end
      return r;
   endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// Per-channel requantiser: aligns the bias to the accumulator format, adds it,
// rounds half up and saturates to the output word.
module fixed_round_sat
   import conv_arith_pkg::*;
#(
   parameter int ACC_W     = 30,
   parameter int ACC_FRAC  = 7,
   parameter int B_WIDTH   = 8,
   parameter int B_FRAC    = 4,
   parameter int OUT_WIDTH = 16,
   parameter int OUT_FRAC  = 4,
   parameter int HAS_BIAS  = 1
) (
   input  logic signed [ACC_W-1:0]     acc,
   input  logic signed [B_WIDTH-1:0]   bias,
   output logic signed [OUT_WIDTH-1:0] q
);

   logic signed [63:0]    bias_ext_s;
   logic signed [ACC_W:0] sum_s;
   logic signed [63:0]    res_s;

   // bias alignment, one-bit-wider sum, then round and clamp
   always_comb begin
      bias_ext_s = (HAS_BIAS != 0) ? align_frac(64'(bias), B_FRAC, ACC_FRAC) : 64'sd0;
      sum_s      = (ACC_W+1)'(acc) + (ACC_W+1)'(bias_ext_s);
      res_s      = round_sat(64'(sum_s), ACC_FRAC, OUT_FRAC, OUT_WIDTH);
   end

   assign q = OUT_WIDTH'(res_s);

endmodule

// File: rtl/conv_dp_acc_requant.sv
// OC_PAR parallel DP_SIZE-lane dot-product accumulators with a programmable
// window depth and a fused bias/round/saturate output stage.
module conv_dp_acc_requant
   import conv_arith_pkg::*;
#(
   parameter int IN_WIDTH      = 16,
   parameter int IN_FRAC       = 3,
   parameter int W_WIDTH       = 8,
   parameter int W_FRAC        = 4,
   parameter int B_WIDTH       = 8,
   parameter int B_FRAC        = 4,
   parameter int OUT_WIDTH     = 16,
   parameter int OUT_FRAC      = 4,
   parameter int DP_SIZE       = 4,
   parameter int OC_PAR        = 2,
   parameter int MAX_ACC_DEPTH = 16,
   parameter int HAS_BIAS      = 1,
   localparam int DW           = $clog2(MAX_ACC_DEPTH + 1)
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [DW-1:0]                         acc_depth,
   input  logic [DP_SIZE-1:0][IN_WIDTH-1:0]      data_in_0,
   input  logic                                  data_in_0_valid,
   output logic                                  data_in_0_ready,
   input  logic [OC_PAR*DP_SIZE-1:0][W_WIDTH-1:0] weight,
   input  logic                                  weight_valid,
   output logic                                  weight_ready,
   input  logic [OC_PAR-1:0][B_WIDTH-1:0]        bias,
   input  logic                                  bias_valid,
   output logic                                  bias_ready,
   output logic [OC_PAR-1:0][OUT_WIDTH-1:0]      data_out_0,
   output logic                                  data_out_0_valid,
   input  logic                                  data_out_0_ready,
   output logic                                  busy
);

   localparam int ACC_W    = acc_width(IN_WIDTH, W_WIDTH, DP_SIZE, MAX_ACC_DEPTH);
   localparam int ACC_FRAC = acc_frac(IN_FRAC, W_FRAC);

   logic [DW-1:0]                    cnt_r;
   logic [DW-1:0]                    depth_r;
   logic [DW-1:0]                    depth_eff_s;
   logic                             last_s;
   logic                             slot_ok_s;
   logic                             fire_s;
   logic                             out_valid_r;
   logic signed [ACC_W-1:0]          acc_r [OC_PAR];
   logic signed [ACC_W-1:0]          dot_s [OC_PAR];
   logic signed [ACC_W-1:0]          sum_s [OC_PAR];
   logic [OC_PAR-1:0][OUT_WIDTH-1:0] out_r;
   logic [OC_PAR-1:0][OUT_WIDTH-1:0] rq_s;

   // window depth is live on the first beat and latched afterwards; only the final beat can stall
   always_comb begin
      if (cnt_r == {DW{1'b0}}) begin
         if (acc_depth == {DW{1'b0}}) begin
            depth_eff_s = DW'(1'b1);
         end else begin
            depth_eff_s = acc_depth;
         end
      end else begin
         depth_eff_s = depth_r;
      end
      last_s = (cnt_r == depth_eff_s - DW'(1'b1));
      if (!rst) begin
         slot_ok_s = 1'b0;
      end else if (!last_s) begin
         slot_ok_s = 1'b1;
      end else begin
         slot_ok_s = (!out_valid_r | data_out_0_ready) & ((HAS_BIAS == 0) | bias_valid);
      end
   end

   assign fire_s           = data_in_0_valid & weight_valid & slot_ok_s;
   assign data_in_0_ready  = weight_valid & slot_ok_s;
   assign weight_ready     = data_in_0_valid & slot_ok_s;
   assign bias_ready       = (HAS_BIAS != 0) ? (fire_s & last_s) : rst;
   assign busy             = (cnt_r != {DW{1'b0}});
   assign data_out_0       = out_r;
   assign data_out_0_valid = out_valid_r;

   // this beat's dot products and the running sums they produce
   always_comb begin
      for (int i = 0; i < OC_PAR; i++) begin
         dot_s[i] = {ACC_W{1'b0}};
         for (int k = 0; k < DP_SIZE; k++) begin
            dot_s[i] = dot_s[i] + ACC_W'($signed(data_in_0[k])) * ACC_W'($signed(weight[i*DP_SIZE+k]));
         end
         if (cnt_r == {DW{1'b0}}) begin
            sum_s[i] = dot_s[i];
         end else begin
            sum_s[i] = acc_r[i] + dot_s[i];
         end
      end
   end

   for (genvar gi = 0; gi < OC_PAR; gi++) begin : g_rq
      fixed_round_sat #(
         .ACC_W    (ACC_W),
         .ACC_FRAC (ACC_FRAC),
         .B_WIDTH  (B_WIDTH),
         .B_FRAC   (B_FRAC),
         .OUT_WIDTH(OUT_WIDTH),
         .OUT_FRAC (OUT_FRAC),
         .HAS_BIAS (HAS_BIAS)
      ) u_rq (
         .acc (sum_s[gi]),
         .bias($signed(bias[gi])),
         .q   (rq_s[gi])
      );
   end

   // beat counter, accumulators and output register
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_r       <= {DW{1'b0}};
         depth_r     <= {DW{1'b0}};
         out_valid_r <= 1'b0;
         out_r       <= {(OC_PAR*OUT_WIDTH){1'b0}};
         for (int i = 0; i < OC_PAR; i++) begin
            acc_r[i] <= {ACC_W{1'b0}};
         end
      end else begin
         if (fire_s) begin
            for (int i = 0; i < OC_PAR; i++) begin
               acc_r[i] <= sum_s[i];
            end
            if (cnt_r == {DW{1'b0}}) begin
               depth_r <= depth_eff_s;
            end
            if (last_s) begin
               cnt_r <= {DW{1'b0}};
            end else begin
               cnt_r <= cnt_r + DW'(1'b1);
            end
         end
         // a drain and a new result in the same cycle reload the register and keep valid high
         if (fire_s & last_s) begin
            out_r       <= rq_s;
            out_valid_r <= 1'b1;
         end else if (data_out_0_ready) begin
            out_valid_r <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_conv_dp_acc_requant.sv
// Self-checking bench: directed windows with hand-computed results plus a
// randomized run, all compared every cycle against a behavioural window model.
module tb_conv_dp_acc_requant;

   localparam int IN_WIDTH  = 16;
   localparam int IN_FRAC   = 3;
   localparam int W_WIDTH   = 8;
   localparam int W_FRAC    = 4;
   localparam int B_WIDTH   = 8;
   localparam int B_FRAC    = 4;
   localparam int OUT_WIDTH = 16;
   localparam int OUT_FRAC  = 4;
   localparam int DP        = 4;
   localparam int OC        = 2;
   localparam int MAXD      = 16;
   localparam int DW        = 5;
   localparam int ACC_FRAC  = IN_FRAC + W_FRAC;
   localparam int SH        = ACC_FRAC - OUT_FRAC;

   logic clk = 1'b0;
   logic rst;
   logic [DW-1:0] acc_depth;
   logic [DP-1:0][IN_WIDTH-1:0] data;
   logic dv, dr;
   logic [OC*DP-1:0][W_WIDTH-1:0] wt;
   logic wv, wr;
   logic [OC-1:0][B_WIDTH-1:0] bias;
   logic bv, br;
   logic [OC-1:0][OUT_WIDTH-1:0] dout;
   logic ov, ordy;
   logic busy;

   always #5 clk = ~clk;

   conv_dp_acc_requant #(
      .IN_WIDTH(IN_WIDTH), .IN_FRAC(IN_FRAC), .W_WIDTH(W_WIDTH), .W_FRAC(W_FRAC),
      .B_WIDTH(B_WIDTH), .B_FRAC(B_FRAC), .OUT_WIDTH(OUT_WIDTH), .OUT_FRAC(OUT_FRAC),
      .DP_SIZE(DP), .OC_PAR(OC), .MAX_ACC_DEPTH(MAXD), .HAS_BIAS(1)
   ) dut (
      .clk(clk), .rst(rst), .acc_depth(acc_depth),
      .data_in_0(data), .data_in_0_valid(dv), .data_in_0_ready(dr),
      .weight(wt), .weight_valid(wv), .weight_ready(wr),
      .bias(bias), .bias_valid(bv), .bias_ready(br),
      .data_out_0(dout), .data_out_0_valid(ov), .data_out_0_ready(ordy),
      .busy(busy)
   );

   int errors = 0;
   int checks = 0;
   int bias_pulses = 0;
   int dut_fires = 0;
   bit final_seen = 1'b0;

   // window model: beat position, latched depth, running dot-product sums, output slot
   int     m_cnt = 0;
   int     m_depth = 1;
   longint m_acc [OC];
   bit     m_ov = 1'b0;
   longint m_out [OC];

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic longint requant(input longint a, input longint b);
      longint v, r, hi, lo;
      v  = a + b * (longint'(1) << (ACC_FRAC - B_FRAC));
      r  = (v + (longint'(1) << (SH - 1))) >>> SH;
      hi = (longint'(1) << (OUT_WIDTH - 1)) - 1;
      lo = -(longint'(1) << (OUT_WIDTH - 1));
      if (r > hi) r = hi;
      if (r < lo) r = lo;
      return r;
   endfunction

   task automatic step();
      int de;
      bit last, slot, fire;
      @(negedge clk);
      #1;
      if (m_cnt == 0) de = (acc_depth == 0) ? 1 : int'(acc_depth);
      else de = m_depth;
      last = (m_cnt == de - 1);
      slot = rst && (!last || ((!m_ov || ordy) && bv));
      fire = dv && wv && slot;
      chk("data_in_0_ready", dr, wv && slot);
      chk("weight_ready", wr, dv && slot);
      chk("bias_ready", br, fire && last);
      if (br === 1'b1) bias_pulses++;
      if ((dv & dr & wv & wr) === 1'b1) dut_fires++;
      @(posedge clk);
      if (!rst) begin
         m_cnt = 0;
         m_ov  = 1'b0;
         for (int i = 0; i < OC; i++) m_out[i] = 0;
      end else begin
         if (fire) begin
            if (m_cnt == 0) begin
               m_depth = de;
               for (int i = 0; i < OC; i++) m_acc[i] = 0;
            end
            for (int i = 0; i < OC; i++)
               for (int k = 0; k < DP; k++)
                  m_acc[i] += longint'($signed(data[k])) * longint'($signed(wt[i*DP+k]));
         end
         if (fire && last) begin
            for (int i = 0; i < OC; i++) m_out[i] = requant(m_acc[i], longint'($signed(bias[i])));
            m_ov  = 1'b1;
            m_cnt = 0;
            final_seen = 1'b1;
         end else begin
            if (fire) m_cnt++;
            if (ordy) m_ov = 1'b0;
         end
      end
      #1;
      chk("out_valid", ov, m_ov);
      chk("busy", busy, m_cnt != 0);
      for (int i = 0; i < OC; i++) chk($sformatf("data_out[%0d]", i), $signed(dout[i]), m_out[i]);
   endtask

   task automatic until_final(input int bound);
      int t = 0;
      final_seen = 1'b0;
      while (!final_seen && t < bound) begin
         step();
         t++;
      end
      chk("window_completes", final_seen, 1);
   endtask

   task automatic set_all(input int d, input int w, input int b0, input int b1);
      for (int k = 0; k < DP; k++) data[k] = IN_WIDTH'(d);
      for (int k = 0; k < OC*DP; k++) wt[k] = W_WIDTH'(w);
      bias[0] = B_WIDTH'(b0);
      bias[1] = B_WIDTH'(b1);
   endtask

   task automatic randomize_beat(input bit extremes);
      for (int k = 0; k < DP; k++) begin
         case (extremes ? $urandom_range(0, 3) : 3)
            0: data[k] = 16'h7FFF;
            1: data[k] = 16'h8000;
            default: data[k] = IN_WIDTH'($urandom);
         endcase
      end
      for (int k = 0; k < OC*DP; k++) begin
         case (extremes ? $urandom_range(0, 3) : 3)
            0: wt[k] = 8'h7F;
            1: wt[k] = 8'h80;
            default: wt[k] = W_WIDTH'($urandom);
         endcase
      end
      bias[0] = B_WIDTH'($urandom);
      bias[1] = B_WIDTH'($urandom);
   endtask

   initial begin
      rst = 1'b0; dv = 1'b0; wv = 1'b0; bv = 1'b0; ordy = 1'b1;
      acc_depth = 5'd2;
      set_all(0, 0, 0, 0);
      repeat (3) step();
      rst = 1'b1;

      // 1.0 x 1.0 over 4 lanes and 2 beats = 8.0
      set_all(8, 16, 0, 0);
      dv = 1'b1; wv = 1'b1; bv = 1'b1;
      bias_pulses = 0;
      until_final(10);
      chk("lit_unity_ch0", $signed(dout[0]), 128);
      chk("lit_unity_ch1", $signed(dout[1]), 128);
      chk("lit_unity_valid", ov, 1);
      chk("lit_bias_pulses_a", bias_pulses, 1);

      // bias +0.5 / -1.0
      set_all(8, 16, 8, -16);
      bias_pulses = 0;
      until_final(10);
      chk("lit_bias_ch0", $signed(dout[0]), 136);
      chk("lit_bias_ch1", $signed(dout[1]), 112);
      chk("lit_bias_pulses_b", bias_pulses, 1);

      // saturation both ways at full depth
      acc_depth = 5'd16;
      set_all(32767, 127, 0, 0);
      until_final(40);
      chk("lit_sat_pos", $signed(dout[0]), 32767);
      set_all(-32767, 127, 0, 0);
      until_final(40);
      chk("lit_sat_neg", $signed(dout[1]), -32768);

      // half-LSB rounding: +4.5 -> 5, -4.5 -> -4
      acc_depth = 5'd1;
      set_all(0, 1, 0, 0);
      data[0] = 16'd36;
      until_final(5);
      chk("lit_round_pos", $signed(dout[0]), 5);
      data[0] = -16'sd36;
      until_final(5);
      chk("lit_round_neg", $signed(dout[1]), -4);
      dv = 1'b0; wv = 1'b0;
      step();

      // blocked output: one full window, three more beats, then the final beat stalls
      ordy = 1'b0;
      acc_depth = 5'd4;
      dv = 1'b1; wv = 1'b1; bv = 1'b1;
      dut_fires = 0;
      repeat (14) begin
         randomize_beat(1'b0);
         step();
      end
      chk("lit_fires_during_hold", dut_fires, 7);
      ordy = 1'b1;
      repeat (20) begin
         randomize_beat(1'b0);
         step();
      end

      // reset after 3 of 8 beats, then a clean window with a mid-window depth change
      dv = 1'b0; wv = 1'b0;
      repeat (2) step();
      acc_depth = 5'd8;
      set_all(8, 16, 0, 0);
      dv = 1'b1; wv = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      step();
      chk("lit_busy_after_reset", busy, 0);
      chk("lit_valid_after_reset", ov, 0);
      rst = 1'b1;
      dut_fires = 0;
      repeat (3) step();
      acc_depth = 5'd2;
      until_final(20);
      chk("lit_after_reset_result", $signed(dout[0]), 512);
      chk("lit_after_reset_beats", dut_fires, 8);

      // randomized traffic
      repeat (3000) begin
         dv   = ($urandom_range(0, 3) != 0);
         wv   = ($urandom_range(0, 3) != 0);
         bv   = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 2) != 0);
         acc_depth = DW'($urandom_range(0, MAXD));
         rst  = ($urandom_range(0, 199) != 0);
         randomize_beat($urandom_range(0, 1) == 1);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
